// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the CPU fetch port and the
// data port: round-robin tie-break, one transaction in flight, one-cycle
// acknowledge per request, and a watchdog that aborts stalled transactions.
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [2:0]    d_dmtype,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [2:0]    m_dmtype,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_rvalid,
    output logic          busy
);

    localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic {
        GR_IF,
        GR_D
    } port_t;

    state_t         state;
    state_t         state_next;
    port_t          last_grant;
    port_t          cur_port;
    port_t          grant_port;
    logic           grant;
    logic           done_ok;
    logic           done_tmo;
    logic [CW-1:0]  cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: arbitration in IDLE, completion/timeout in WAIT
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_port = GR_IF;
        done_ok    = 1'b0;
        done_tmo   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (if_req || d_req) begin
                    grant      = 1'b1;
                    grant_port = (d_req && (!if_req || last_grant == GR_IF)) ? GR_D : GR_IF;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_rvalid) begin
                    done_ok    = 1'b1;
                    state_next = S_RESP;
                end else if (cnt == CW'(TMO - 1)) begin
                    done_tmo   = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Command latching, watchdog counter, and per-port response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_dmtype   <= '0;
            cnt        <= '0;
            last_grant <= GR_IF;
            cur_port   <= GR_IF;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            err        <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            m_req  <= grant;
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            err    <= 1'b0;
            if (grant) begin
                last_grant <= grant_port;
                cur_port   <= grant_port;
                cnt        <= '0;
                if (grant_port == GR_D) begin
                    m_we     <= d_we;
                    m_addr   <= d_addr;
                    m_wdata  <= d_wdata;
                    m_dmtype <= d_dmtype;
                end else begin
                    m_we     <= 1'b0;
                    m_addr   <= if_addr;
                    m_wdata  <= '0;
                    m_dmtype <= '0;
                end
            end else if (state == S_WAIT) begin
                cnt <= cnt + CW'(1);
            end
            if (done_ok || done_tmo) begin
                err <= done_tmo;
                if (cur_port == GR_D) begin
                    d_ack   <= 1'b1;
                    d_rdata <= done_ok ? m_rdata : '0;
                end else begin
                    if_ack   <= 1'b1;
                    if_rdata <= done_ok ? m_rdata : '0;
                end
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [2:0]    d_dmtype;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          err;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [2:0]    m_dmtype;
    logic [DW-1:0] m_rdata;
    logic          m_rvalid;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_dmtype(d_dmtype), .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_dmtype(m_dmtype), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .busy(busy)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL time_limit: simulation did not finish, got timeout exp completion");
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [136:0] outs();
        return {if_ack, if_rdata, d_ack, d_rdata, err, m_req, m_we,
                m_addr, m_wdata, m_dmtype, busy};
    endfunction

    task automatic clear_inputs;
        if_req   = 1'b0;
        if_addr  = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        d_dmtype = '0;
        m_rdata  = '0;
        m_rvalid = 1'b0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst      = 1'b1;
        m_rvalid = 1'b1;
        tick();
        tick();
        n_tests++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h exp 0", outs());
        end
        rst      = 1'b0;
        m_rvalid = 1'b0;
        tick();
        n_tests++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h exp 0", outs());
        end
    endtask

    task automatic test_single_fetch;
        apply_reset();
        if_req  = 1'b1;
        if_addr = 32'h10;
        tick();
        n_tests++;
        if (m_req !== 1'b1 || busy !== 1'b1 || m_addr !== 32'h10 || m_we !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_cmd: got req=%b busy=%b addr=%h we=%b exp req=1 busy=1 addr=10 we=0",
                     m_req, busy, m_addr, m_we);
        end
        m_rvalid = 1'b1;
        m_rdata  = 32'h00500093;
        tick();
        n_tests++;
        if (if_ack !== 1'b1 || d_ack !== 1'b0 || err !== 1'b0 || m_req !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_ack: got if_ack=%b d_ack=%b err=%b m_req=%b exp 1 0 0 0",
                     if_ack, d_ack, err, m_req);
        end
        n_tests++;
        if (if_rdata !== 32'h00500093) begin
            n_fail++;
            $display("FAIL fetch_rdata: got %h exp 00500093", if_rdata);
        end
        m_rvalid = 1'b0;
        m_rdata  = '0;
        if_req   = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || if_ack !== 1'b0 || if_rdata !== 32'h00500093) begin
            n_fail++;
            $display("FAIL fetch_done: got busy=%b ack=%b rdata=%h exp 0 0 00500093",
                     busy, if_ack, if_rdata);
        end
    endtask

    task automatic test_tie;
        apply_reset();
        if_req   = 1'b1;
        if_addr  = 32'h40;
        d_req    = 1'b1;
        d_we     = 1'b1;
        d_addr   = 32'h100;
        d_wdata  = 32'hDEADBEEF;
        d_dmtype = 3'b010;
        tick();
        n_tests++;
        if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h100 ||
            m_wdata !== 32'hDEADBEEF || m_dmtype !== 3'b010) begin
            n_fail++;
            $display("FAIL tie_first_data: got req=%b we=%b addr=%h wdata=%h mt=%b exp 1 1 100 deadbeef 010",
                     m_req, m_we, m_addr, m_wdata, m_dmtype);
        end
        m_rvalid = 1'b1;
        m_rdata  = 32'h11111111;
        tick();
        n_tests++;
        if (d_ack !== 1'b1 || if_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_data_ack: got d_ack=%b if_ack=%b exp 1 0", d_ack, if_ack);
        end
        m_rvalid = 1'b0;
        tick();
        tick();
        n_tests++;
        if (m_req !== 1'b1 || m_addr !== 32'h40 || m_we !== 1'b0 ||
            m_wdata !== 32'h0 || m_dmtype !== 3'b000) begin
            n_fail++;
            $display("FAIL tie_second_if: got req=%b addr=%h we=%b wdata=%h mt=%b exp 1 40 0 0 000",
                     m_req, m_addr, m_we, m_wdata, m_dmtype);
        end
        m_rvalid = 1'b1;
        m_rdata  = 32'h22222222;
        tick();
        n_tests++;
        if (if_ack !== 1'b1 || d_ack !== 1'b0 || if_rdata !== 32'h22222222) begin
            n_fail++;
            $display("FAIL tie_if_ack: got if_ack=%b d_ack=%b rdata=%h exp 1 0 22222222",
                     if_ack, d_ack, if_rdata);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_alternate_back_to_back;
        int order[$];
        int gcyc[$];
        int cyc;
        apply_reset();
        if_req  = 1'b1;
        if_addr = 32'h40;
        d_req   = 1'b1;
        d_addr  = 32'h100;
        cyc     = 0;
        for (int c = 0; c < 40 && order.size() < 6; c++) begin
            tick();
            cyc++;
            m_rvalid = 1'b0;
            if (m_req) begin
                order.push_back((m_addr == 32'h100) ? 1 : 0);
                gcyc.push_back(cyc);
                m_rvalid = 1'b1;
                m_rdata  = 32'(cyc);
            end
        end
        tick();
        clear_inputs();
        tick();
        n_tests++;
        if (order.size() != 6) begin
            n_fail++;
            $display("FAIL alt_count: got %0d grants exp 6", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            n_tests++;
            if (order[i] != ((i % 2 == 0) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL alt_order[%0d]: got data=%0d exp data=%0d", i, order[i], (i % 2 == 0) ? 1 : 0);
            end
        end
        for (int i = 1; i < gcyc.size(); i++) begin
            n_tests++;
            if (gcyc[i] - gcyc[i-1] != 3) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles exp 3", i, gcyc[i] - gcyc[i-1]);
            end
        end
    endtask

    task automatic test_timeout;
        bit got;
        int k;
        apply_reset();
        d_req  = 1'b1;
        d_addr = 32'h80;
        tick();
        m_rvalid = 1'b1;
        m_rdata  = 32'h12345678;
        tick();
        m_rvalid = 1'b0;
        n_tests++;
        if (d_ack !== 1'b1 || err !== 1'b0 || d_rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL tmo_pre_load: got ack=%b err=%b rdata=%h exp 1 0 12345678", d_ack, err, d_rdata);
        end
        d_req = 1'b0;
        tick();
        d_req  = 1'b1;
        d_addr = 32'h84;
        tick();
        n_tests++;
        if (m_req !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_cmd: got m_req=%b exp 1", m_req);
        end
        got = 1'b0;
        k   = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            tick();
            if (d_ack) begin
                got = 1'b1;
                k   = i;
            end
        end
        n_tests++;
        if (!got || k != TMO || err !== 1'b1 || d_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL tmo_abort: got ack=%b after %0d err=%b rdata=%h exp ack after %0d err=1 rdata=0",
                     got, k, err, d_rdata, TMO);
        end
        d_req = 1'b0;
        tick();
        n_tests++;
        if (err !== 1'b0 || d_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_err_clear: got err=%b ack=%b exp 0 0", err, d_ack);
        end
        d_req  = 1'b1;
        d_addr = 32'h88;
        tick();
        m_rvalid = 1'b1;
        m_rdata  = 32'hCAFEF00D;
        tick();
        m_rvalid = 1'b0;
        n_tests++;
        if (d_ack !== 1'b1 || err !== 1'b0 || d_rdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL tmo_recover: got ack=%b err=%b rdata=%h exp 1 0 cafef00d", d_ack, err, d_rdata);
        end
        d_req = 1'b0;
        tick();
        // rvalid on the last watchdog cycle must complete normally
        d_req  = 1'b1;
        d_addr = 32'h8C;
        tick();
        for (int i = 1; i < TMO; i++) tick();
        m_rvalid = 1'b1;
        m_rdata  = 32'h5A5A5A5A;
        tick();
        m_rvalid = 1'b0;
        n_tests++;
        if (d_ack !== 1'b1 || err !== 1'b0 || d_rdata !== 32'h5A5A5A5A) begin
            n_fail++;
            $display("FAIL tmo_coincide: got ack=%b err=%b rdata=%h exp 1 0 5a5a5a5a", d_ack, err, d_rdata);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid;
        apply_reset();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h200;
        tick();
        tick();
        rst   = 1'b1;
        d_req = 1'b0;
        tick();
        n_tests++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h exp 0", outs());
        end
        rst      = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'hBADBAD00;
        tick();
        m_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (outs() !== '0) begin
                n_fail++;
                $display("FAIL rstmid_late_rvalid[%0d]: got %h exp 0", i, outs());
            end
            tick();
        end
    endtask

    task automatic test_latch;
        bit got;
        int k;
        apply_reset();
        d_req    = 1'b1;
        d_we     = 1'b0;
        d_addr   = 32'h2C0;
        d_dmtype = 3'b100;
        got = 1'b0;
        k   = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            tick();
            m_rvalid = 1'b0;
            if (d_ack) begin
                got = 1'b1;
                k   = i;
            end else begin
                n_tests++;
                if (m_addr !== 32'h2C0 || m_dmtype !== 3'b100) begin
                    n_fail++;
                    $display("FAIL latch_addr[%0d]: got addr=%h mt=%b exp 2c0 100", i, m_addr, m_dmtype);
                end
            end
            if (i == 2) begin
                d_addr   = 32'h300;
                d_dmtype = 3'b001;
            end
            if (i == 6) begin
                m_rvalid = 1'b1;
                m_rdata  = 32'h0BADF00D;
            end
        end
        n_tests++;
        if (!got || k != 7 || d_rdata !== 32'h0BADF00D || err !== 1'b0) begin
            n_fail++;
            $display("FAIL latch_ack: got ack=%b at %0d rdata=%h err=%b exp ack at 7 rdata=0badf00d err=0",
                     got, k, d_rdata, err);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random;
        bit            ip, dp;
        logic [AW-1:0] ia, da;
        logic          dwe;
        logic [DW-1:0] dwd;
        logic [2:0]    dmt;
        bit            snap_i, snap_d, last_d;
        bit            infl, inf_d, inf_tmo;
        int            rv_cyc, ack_cyc, done;
        logic [DW-1:0] exp_data;
        apply_reset();
        ip = 0; dp = 0; ia = '0; da = '0; dwe = 0; dwd = '0; dmt = '0;
        snap_i = 0; snap_d = 0; last_d = 0;
        infl = 0; inf_d = 0; inf_tmo = 0; rv_cyc = -1; ack_cyc = 0; done = 0;
        exp_data = '0;
        for (int cyc = 1; cyc <= 3000 && done < 40; cyc++) begin
            tick();
            m_rvalid = 1'b0;
            m_rdata  = DW'($urandom);
            if (if_ack || d_ack) begin
                n_tests++;
                if (!infl || if_ack !== !inf_d || d_ack !== inf_d || cyc != ack_cyc ||
                    err !== inf_tmo || (inf_d ? d_rdata : if_rdata) !== exp_data) begin
                    n_fail++;
                    $display("FAIL rand_ack@%0d: got if_ack=%b d_ack=%b err=%b rdata=%h exp port_d=%b cyc=%0d err=%b rdata=%h",
                             cyc, if_ack, d_ack, err, inf_d ? d_rdata : if_rdata, inf_d, ack_cyc, inf_tmo, exp_data);
                end
                if (infl) begin
                    if (inf_d) dp = 0;
                    else ip = 0;
                end
                infl = 0;
                done++;
            end else if (infl && cyc > ack_cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL rand_missing_ack@%0d: got no ack exp ack at %0d", cyc, ack_cyc);
                if (inf_d) dp = 0;
                else ip = 0;
                infl = 0;
                done++;
            end
            if (m_req) begin
                bit exp_d;
                exp_d = snap_d && (!snap_i || !last_d);
                n_tests++;
                if (infl || !(snap_i || snap_d) || m_addr !== (exp_d ? da : ia) ||
                    m_we !== (exp_d ? dwe : 1'b0) || m_wdata !== (exp_d ? dwd : '0) ||
                    m_dmtype !== (exp_d ? dmt : 3'b000)) begin
                    n_fail++;
                    $display("FAIL rand_grant@%0d: got addr=%h we=%b wdata=%h mt=%b exp port_d=%b addr=%h",
                             cyc, m_addr, m_we, m_wdata, m_dmtype, exp_d, exp_d ? da : ia);
                end
                last_d = exp_d;
                infl   = 1;
                inf_d  = exp_d;
                if ($urandom_range(0, 7) == 0) begin
                    inf_tmo  = 1;
                    exp_data = '0;
                    rv_cyc   = -1;
                    ack_cyc  = cyc + TMO;
                end else begin
                    inf_tmo  = 0;
                    exp_data = DW'($urandom);
                    rv_cyc   = cyc + int'($urandom_range(0, 3));
                    ack_cyc  = rv_cyc + 1;
                end
            end
            if (infl && !inf_tmo && cyc == rv_cyc) begin
                m_rvalid = 1'b1;
                m_rdata  = exp_data;
            end else if (!infl && $urandom_range(0, 3) == 0) begin
                m_rvalid = 1'b1;
            end
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1;
                ia = AW'($urandom);
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp  = 1;
                da  = AW'($urandom);
                dwe = 1'($urandom_range(0, 1));
                dwd = DW'($urandom);
                dmt = 3'($urandom_range(0, 7));
            end
            if_req   = ip;
            if_addr  = ia;
            d_req    = dp;
            d_addr   = da;
            d_we     = dwe;
            d_wdata  = dwd;
            d_dmtype = dmt;
            snap_i   = ip;
            snap_d   = dp;
        end
        n_tests++;
        if (done < 40) begin
            n_fail++;
            $display("FAIL rand_progress: got %0d transactions exp 40", done);
        end
        clear_inputs();
        tick();
    endtask

    // Scenario sequence
    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_single_fetch();
        test_tie();
        test_alternate_back_to_back();
        test_timeout();
        test_reset_mid();
        test_latch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
